// File: rtl/mailbox_apb_initiator.sv
// APB3 requester: one valid/ready command -> one APB transfer -> one response; min 3 cycles accept->rsp_valid.
// Single outstanding command; cmd_ready low until the response is consumed. MAILBOX_APB_INIT_TIMEOUT_EN adds a pready watchdog.
module mailbox_apb_initiator #(
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        psel,
  output logic        penable,
  output logic [31:0] paddr,
  output logic        pwrite,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t state;

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("mailbox_apb_initiator: TIMEOUT_CYCLES must be >= 1");
  end

  // Registers are word-aligned; byte-offset bits are dropped.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^cmd_addr[1:0];

`ifdef MAILBOX_APB_INIT_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] tcnt;
`endif

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef MAILBOX_APB_INIT_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            psel      <= 1'b1;
            penable   <= 1'b0;
            paddr     <= BASE_ADDR | {26'b0, cmd_addr[5:2], 2'b00};
            pwrite    <= cmd_write;
            pwdata    <= cmd_write ? cmd_wdata : 32'h0;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
`ifdef MAILBOX_APB_INIT_TIMEOUT_EN
          tcnt    <= '0;
`endif
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          // pready on the limit cycle still completes normally.
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr;
            rsp_rdata <= (!pwrite && !pslverr) ? prdata : 32'h0;
            state     <= S_RESP;
          end
`ifdef MAILBOX_APB_INIT_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
            state     <= S_RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mailbox_apb_initiator.sv
// Bench for mailbox_apb_initiator: directed + random commands against a wait-state APB target model,
// responses checked through an expected-response queue.
module tb_mailbox_apb_initiator;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  mailbox_apb_initiator #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(8)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // APB target model: pready after slv_wait unready ACCESS cycles unless stuck.
  int          slv_wait  = 0;
  logic        slv_stuck = 1'b0;
  logic        slv_err   = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          acc_cnt   = 0;

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  assign pready  = !slv_stuck && (acc_cnt >= slv_wait);
  assign pslverr = slv_err;
  assign prdata  = slv_rdata;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic offer(input logic w, input logic [5:0] a, input logic [31:0] wd, input string tag);
    int bound;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    bound = 0;
    while (!cmd_ready && bound < 50) begin
      tick();
      bound++;
    end
    chk({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'h1);
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = ~a;
    cmd_wdata = ~wd;
  endtask

  task automatic run_cmd(input string tag, input logic w, input logic [5:0] a, input logic [31:0] wd,
                         input int wait_n, input logic err, input logic [31:0] rd, input logic stuck,
                         input int exp_en, input int hold);
    logic [31:0] exp_addr, exp_wdata, cap_rdata;
    logic        cap_err, bad;
    int          n_en, lat;
    exp_t        e;
    exp_addr  = BASE | {26'b0, a[5:2], 2'b00};
    exp_wdata = w ? wd : 32'h0;
    slv_wait  = wait_n;
    slv_err   = err;
    slv_rdata = rd;
    slv_stuck = stuck;
    rsp_ready = (hold == 0);
    e.err   = err | stuck;
    e.rdata = (w || err || stuck) ? 32'h0 : rd;
    sb.push_back(e);

    offer(w, a, wd, tag);
    chk({tag, "_setup_psel"}, {30'b0, psel, penable}, 32'h2);
    chk({tag, "_paddr"}, paddr, exp_addr);
    chk({tag, "_pwrite"}, {31'b0, pwrite}, {31'b0, w});
    chk({tag, "_pwdata"}, pwdata, exp_wdata);

    n_en = 0;
    lat  = 1;
    bad  = 1'b0;
    while (!rsp_valid && lat < 300) begin
      tick();
      lat++;
      if (psel && penable) begin
        n_en++;
        if (paddr !== exp_addr || pwrite !== w || pwdata !== exp_wdata || cmd_ready) bad = 1'b1;
      end
    end
    chk({tag, "_access_stable"}, {31'b0, bad}, 32'h0);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'h1);
    if (!rsp_valid) return;
    chk({tag, "_latency"}, lat, exp_en + 2);
    chk({tag, "_penable_cycles"}, n_en, exp_en);
    chk({tag, "_resp_psel"}, {30'b0, psel, penable}, 32'h0);

    cap_rdata = rsp_rdata;
    cap_err   = rsp_err;
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!rsp_valid || rsp_rdata !== cap_rdata || rsp_err !== cap_err || cmd_ready || psel) bad = 1'b1;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, {31'b0, bad}, 32'h0);

    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
    end
    rsp_ready = 1'b1;
    tick();
    chk({tag, "_post_rsp"}, {29'b0, rsp_valid, psel, cmd_ready}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

  initial begin
    logic        bad;
    logic        rw;
    logic [5:0]  ra;
    logic [31:0] rwd, rrd;
    int          rwait;

    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 6'h0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    chk("rst_ctrl", {26'b0, cmd_ready, psel, penable, pwrite, rsp_valid, rsp_err}, 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    preset = 1'b0;
    tick();
    chk("idle_cmd_ready", {31'b0, cmd_ready}, 32'h1);

    run_cmd("wr_basic", 1'b1, 6'h08, 32'hDEAD_BEEF, 0, 1'b0, 32'h5555_AAAA, 1'b0, 1, 0);
    run_cmd("rd_wait4", 1'b0, 6'h0C, 32'h0, 4, 1'b0, 32'h1234_5678, 1'b0, 5, 0);
    run_cmd("rd_slverr", 1'b0, 6'h10, 32'h0, 0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1, 0);
    run_cmd("b2b_wr0", 1'b1, 6'h14, 32'h0BAD_F00D, 0, 1'b0, 32'h0, 1'b0, 1, 0);
    run_cmd("b2b_wr1", 1'b1, 6'h3F, 32'hCAFE_0001, 0, 1'b0, 32'h0, 1'b0, 1, 0);
    run_cmd("rsp_hold", 1'b0, 6'h20, 32'h0, 1, 1'b0, 32'hA5A5_5A5A, 1'b0, 2, 10);

    // Reset in the middle of a stalled ACCESS phase.
    slv_stuck = 1'b1;
    offer(1'b0, 6'h18, 32'h0, "rst_mid");
    tick();
    tick();
    chk("rst_mid_in_access", {30'b0, psel, penable}, 32'h3);
    preset = 1'b1;
    tick();
    chk("rst_mid_apb_drop", {29'b0, psel, penable, rsp_valid}, 32'h0);
    preset    = 1'b0;
    slv_stuck = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid || psel) bad = 1'b1;
    end
    chk("rst_mid_no_rsp", {31'b0, bad}, 32'h0);
    chk("rst_mid_ready", {31'b0, cmd_ready}, 32'h1);

`ifdef MAILBOX_APB_INIT_TIMEOUT_EN
    run_cmd("timeout", 1'b0, 6'h24, 32'h0, 0, 1'b0, 32'h7777_7777, 1'b1, 8, 0);
    run_cmd("limit_wins", 1'b0, 6'h28, 32'h0, 7, 1'b0, 32'h0F0F_0F0F, 1'b0, 8, 0);
`endif

    for (int k = 0; k < 6; k++) begin
      rw    = 1'($urandom_range(0, 1));
      ra    = 6'($urandom_range(0, 63));
      rwd   = $urandom;
      rrd   = $urandom;
      rwait = $urandom_range(0, 3);
      run_cmd($sformatf("rand%0d", k), rw, ra, rwd, rwait, 1'b0, rrd, 1'b0, rwait + 1, k % 3);
    end

    chk("sb_drained", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
